// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, encodings and store formatting helpers for the load/store stage
package lsu_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] LSU_B = 2'b00;
    localparam logic [1:0] LSU_H = 2'b01;
    localparam logic [1:0] LSU_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_RESP = 2'b11
    } lsu_state_e;

    // uns stands in for "unsigned", which is a reserved word
    typedef struct packed {
        logic            we;
        logic [1:0]      size;
        logic            uns;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic [4:0]      rd;
    } lsu_op_t;

    // size 11 is never aligned, so illegal ops share the misalign path
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            LSU_B:   return 1'b1;
            LSU_H:   return ~off[0];
            LSU_W:   return (off == 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] off);
        case (size)
            LSU_B:   return 4'b0001 << off;
            LSU_H:   return 4'b0011 << off;
            LSU_W:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // replicate across lanes so the byte enables alone select the target bytes
    function automatic logic [XLEN-1:0] store_data(input logic [1:0] size, input logic [XLEN-1:0] wdata);
        case (size)
            LSU_B:   return {4{wdata[7:0]}};
            LSU_H:   return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - single-outstanding data bus with req/gnt/rvalid handshake
interface mem_stage_if;
    import lsu_pkg::*;

    logic            dbus_req;
    logic            dbus_we;
    logic [XLEN-1:0] dbus_addr;
    logic [XLEN-1:0] dbus_wdata;
    logic [3:0]      dbus_be;
    logic            dbus_gnt;
    logic            dbus_rvalid;
    logic [XLEN-1:0] dbus_rdata;

    modport master (
        output dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_be,
        input  dbus_gnt, dbus_rvalid, dbus_rdata
    );

    modport slave (
        input  dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_be,
        output dbus_gnt, dbus_rvalid, dbus_rdata
    );

endinterface

// File: rtl/mem_stage_load_align.sv
// rtl/mem_stage_load_align.sv - extracts and extends a byte/half/word from a returned bus word
module load_align
    import lsu_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      offset,
    input  logic [1:0]      size,
    input  logic            is_unsigned,
    output logic [XLEN-1:0] result
);

    logic [XLEN-1:0] shifted;

    // move the addressed lane to bit 0, then extend from its top bit
    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        case (size)
            LSU_B:   result = {{24{shifted[7] & ~is_unsigned}}, shifted[7:0]};
            LSU_H:   result = {{16{shifted[15] & ~is_unsigned}}, shifted[15:0]};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - load/store stage: one outstanding bus access, aligned load result to write_back
module mem_stage
    import lsu_pkg::*;
#(
    parameter int xlen = XLEN
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             lsu_v,
    output logic             lsu_ready,
    input  logic             lsu_we,
    input  logic [1:0]       lsu_size,
    input  logic             lsu_unsigned,
    input  logic [xlen-1:0]  lsu_addr,
    input  logic [xlen-1:0]  lsu_wdata,
    input  logic [4:0]       lsu_rd,
    output logic             misalign,

    mem_stage_if.master      dbus,

    output logic [xlen-1:0]  mem_res,
    output logic [4:0]       mem_rd,
    output logic             mem_res_v,
    input  logic             mem_ok
);

    lsu_state_e      state_q, state_d;
    lsu_op_t         op_q, op_d;
    logic [3:0]      be_q, be_d;
    logic            misalign_q, misalign_d;
    logic [xlen-1:0] res_q, res_d;
    logic [4:0]      rd_q, rd_d;
    logic            res_v_q, res_v_d;
    logic [xlen-1:0] load_res;
    logic            accept;

    assign lsu_ready = (state_q == ST_IDLE) && !rst;
    assign accept    = lsu_v && lsu_ready;

    load_align u_load_align (
        .rdata       (dbus.dbus_rdata),
        .offset      (op_q.addr[1:0]),
        .size        (op_q.size),
        .is_unsigned (op_q.uns),
        .result      (load_res)
    );

    // next-state: accept/format in IDLE, hold request until gnt, capture on rvalid, hold result until mem_ok
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        be_d       = be_q;
        misalign_d = 1'b0;
        res_d      = res_q;
        rd_d       = rd_q;
        res_v_d    = res_v_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_aligned(lsu_size, lsu_addr[1:0])) begin
                        op_d.we    = lsu_we;
                        op_d.size  = lsu_size;
                        op_d.uns   = lsu_unsigned;
                        op_d.addr  = lsu_addr;
                        op_d.wdata = lsu_we ? store_data(lsu_size, lsu_wdata) : '0;
                        op_d.rd    = lsu_rd;
                        be_d       = lsu_we ? store_be(lsu_size, lsu_addr[1:0]) : 4'b0000;
                        state_d    = ST_REQ;
                    end else begin
                        misalign_d = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                if (dbus.dbus_gnt) begin
                    state_d = op_q.we ? ST_IDLE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (dbus.dbus_rvalid) begin
                    res_d   = load_res;
                    rd_d    = op_q.rd;
                    res_v_d = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (mem_ok) begin
                    res_v_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // state and datapath registers; reset abandons any access in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            be_q       <= 4'b0000;
            misalign_q <= 1'b0;
            res_q      <= '0;
            rd_q       <= 5'd0;
            res_v_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            be_q       <= be_d;
            misalign_q <= misalign_d;
            res_q      <= res_d;
            rd_q       <= rd_d;
            res_v_q    <= res_v_d;
        end
    end

    assign dbus.dbus_req   = (state_q == ST_REQ);
    assign dbus.dbus_we    = op_q.we;
    assign dbus.dbus_addr  = {op_q.addr[xlen-1:2], 2'b00};
    assign dbus.dbus_wdata = op_q.wdata;
    assign dbus.dbus_be    = be_q;

    assign misalign  = misalign_q;
    assign mem_res   = res_q;
    assign mem_rd    = rd_q;
    assign mem_res_v = res_v_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard bench for mem_stage with a reference memory model
module tb_mem_stage;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lsu_v = 1'b0, lsu_ready, lsu_we = 1'b0, lsu_unsigned = 1'b0;
    logic [1:0]  lsu_size = 2'b00;
    logic [31:0] lsu_addr = '0, lsu_wdata = '0;
    logic [4:0]  lsu_rd = '0;
    logic        misalign;
    logic [31:0] mem_res;
    logic [4:0]  mem_rd;
    logic        mem_res_v;
    logic        mem_ok = 1'b0;

    mem_stage_if dbus ();

    mem_stage #(.xlen(32)) dut (
        .clk(clk), .rst(rst),
        .lsu_v(lsu_v), .lsu_ready(lsu_ready), .lsu_we(lsu_we), .lsu_size(lsu_size),
        .lsu_unsigned(lsu_unsigned), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_rd(lsu_rd),
        .misalign(misalign), .dbus(dbus),
        .mem_res(mem_res), .mem_rd(mem_rd), .mem_res_v(mem_res_v), .mem_ok(mem_ok)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be; } bus_exp_t;
    typedef struct packed { logic [4:0] rd; logic [31:0] res; } res_exp_t;

    bus_exp_t    bus_q[$];
    res_exp_t    res_q[$];
    bit          mis_q[$];
    logic [31:0] ref_mem[logic [31:0]];
    logic [31:0] bus_mem[logic [31:0]];

    int vectors = 0, miscompares = 0, last_wait = 0;
    int fix_gnt = -1, fix_rv = -1, ok_mode = 0;
    bit mute_rv = 0, stray_req = 0, noise_en = 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: event with no expectation or timeout", name);
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] wa);
        return (wa * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] wa);
        return ref_mem.exists(wa) ? ref_mem[wa] : init_word(wa);
    endfunction

    function automatic logic [31:0] bus_rd(input logic [31:0] wa);
        return bus_mem.exists(wa) ? bus_mem[wa] : init_word(wa);
    endfunction

    task automatic preload(input logic [31:0] wa, input logic [31:0] val);
        ref_mem[wa] = val;
        bus_mem[wa] = val;
    endtask

    // reference model: byte-lane view of memory, expectation pushed at issue, then the op is driven
    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
        int n, o, t;
        logic [31:0] wa, word, val;
        bus_exp_t b;
        n  = (size == 2'b11) ? 0 : (1 << size);
        o  = int'(addr[1:0]);
        wa = {addr[31:2], 2'b00};
        if (n == 0 || (o % n) != 0) begin
            mis_q.push_back(1'b1);
        end else begin
            b = '0;
            b.we = we;
            b.addr = wa;
            word = ref_rd(wa);
            if (we) begin
                for (int i = 0; i < 4; i++) begin
                    b.wdata[8*i +: 8] = wdata[8*(i % n) +: 8];
                    if (i >= o && i < o + n) begin
                        b.be[i] = 1'b1;
                        word[8*i +: 8] = wdata[8*(i - o) +: 8];
                    end
                end
                ref_mem[wa] = word;
            end else begin
                val = '0;
                for (int i = 0; i < n; i++) val[8*i +: 8] = word[8*(o + i) +: 8];
                if (!uns && n < 4 && val[8*n-1]) val = val - (32'd1 << (8*n));
                res_q.push_back('{rd, val});
            end
            bus_q.push_back(b);
        end
        @(negedge clk);
        lsu_v = 1'b1; lsu_we = we; lsu_size = size; lsu_unsigned = uns;
        lsu_addr = addr; lsu_wdata = wdata; lsu_rd = rd;
        t = 0;
        while (!lsu_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        last_wait = t;
        if (!lsu_ready) fail("accept_timeout");
        @(posedge clk);
        #1 lsu_v = 1'b0;
    endtask

    // cycles from acceptance until mem_res_v (want_v) or lsu_ready is seen
    task automatic measure(input string name, input bit want_v, input int exp_cyc);
        int k;
        k = 0;
        do begin
            @(negedge clk); #4;
            k++;
        end while (!(want_v ? mem_res_v : lsu_ready) && k < 20);
        check(name, k, exp_cyc);
    endtask

    task automatic check_reset_outputs();
        check("rst_lsu_ready", lsu_ready, 1);
        check("rst_misalign", misalign, 0);
        check("rst_dbus_req", dbus.dbus_req, 0);
        check("rst_dbus_we", dbus.dbus_we, 0);
        check("rst_dbus_addr", dbus.dbus_addr, 0);
        check("rst_dbus_wdata", dbus.dbus_wdata, 0);
        check("rst_dbus_be", dbus.dbus_be, 0);
        check("rst_mem_res", mem_res, 0);
        check("rst_mem_rd", mem_rd, 0);
        check("rst_mem_res_v", mem_res_v, 0);
    endtask

    // bus slave: random or forced grant delay, read latency and rvalid noise outside WAIT
    initial begin
        int gcnt, gdel, rcnt;
        bit pend;
        logic [31:0] pa, w;
        dbus.dbus_gnt = 0; dbus.dbus_rvalid = 0; dbus.dbus_rdata = '0;
        pend = 0; gcnt = 0; gdel = 0; rcnt = 0; pa = '0;
        forever begin
            @(negedge clk);
            dbus.dbus_gnt = 0; dbus.dbus_rvalid = 0; dbus.dbus_rdata = $urandom;
            if (rst) begin
                pend = 0; gcnt = 0;
            end else if (stray_req) begin
                dbus.dbus_rvalid = 1;
            end else if (pend) begin
                if (rcnt == 0) begin
                    if (!mute_rv) begin
                        dbus.dbus_rvalid = 1; dbus.dbus_rdata = bus_rd(pa); pend = 0;
                    end
                end else rcnt--;
            end else if (dbus.dbus_req) begin
                if (gcnt == 0)
                    gdel = (fix_gnt >= 0) ? fix_gnt : (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
                if (gcnt == gdel) begin
                    dbus.dbus_gnt = 1; gcnt = 0;
                    if (dbus.dbus_we) begin
                        w = bus_rd(dbus.dbus_addr);
                        for (int i = 0; i < 4; i++)
                            if (dbus.dbus_be[i]) w[8*i +: 8] = dbus.dbus_wdata[8*i +: 8];
                        bus_mem[dbus.dbus_addr] = w;
                    end else begin
                        pend = 1; pa = dbus.dbus_addr;
                        rcnt = (fix_rv >= 0) ? fix_rv : int'($urandom_range(0, 3));
                    end
                end else begin
                    gcnt++;
                    if (noise_en) dbus.dbus_rvalid = 1'($urandom_range(0, 1));
                end
            end else if (noise_en && $urandom_range(0, 7) == 0) begin
                dbus.dbus_rvalid = 1;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        mem_ok = (ok_mode == 1) ? 1'b1 : (ok_mode == 2) ? 1'b0 : ($urandom_range(0, 2) != 0);
    end

    // monitor: sampled just before each rising edge
    initial begin
        logic pv_req, pv_gnt, pv_v, pv_ok, p_we;
        logic [31:0] p_addr, p_wdata, p_res;
        logic [3:0] p_be;
        logic [4:0] p_rd;
        bus_exp_t b;
        res_exp_t r;
        bit m;
        pv_req = 0; pv_gnt = 0; pv_v = 0; pv_ok = 0; p_we = 0;
        p_addr = '0; p_wdata = '0; p_res = '0; p_be = '0; p_rd = '0;
        forever begin
            @(negedge clk); #4;
            if (rst) begin
                check("ready_in_reset", lsu_ready, 0);
                pv_req = 0; pv_v = 0;
                continue;
            end
            if (pv_req && !pv_gnt) begin
                check("stall_req", dbus.dbus_req, 1);
                check("stall_addr", dbus.dbus_addr, p_addr);
                check("stall_wdata", dbus.dbus_wdata, p_wdata);
                check("stall_be", dbus.dbus_be, p_be);
                check("stall_we", dbus.dbus_we, p_we);
            end
            if (pv_v && !pv_ok) begin
                check("hold_res_v", mem_res_v, 1);
                check("hold_res", mem_res, p_res);
                check("hold_rd", mem_rd, p_rd);
            end
            if (dbus.dbus_req && dbus.dbus_gnt) begin
                if (bus_q.size() == 0) fail("unexpected_bus_req");
                else begin
                    b = bus_q.pop_front();
                    check("bus_we", dbus.dbus_we, b.we);
                    check("bus_addr", dbus.dbus_addr, b.addr);
                    check("bus_wdata", dbus.dbus_wdata, b.wdata);
                    check("bus_be", dbus.dbus_be, b.be);
                end
            end
            if (mem_res_v) check("ready_in_resp", lsu_ready, 0);
            if (mem_res_v && mem_ok) begin
                if (res_q.size() == 0) fail("unexpected_result");
                else begin
                    r = res_q.pop_front();
                    check("mem_res", mem_res, r.res);
                    check("mem_rd", mem_rd, r.rd);
                end
            end
            if (misalign) begin
                if (mis_q.size() == 0) fail("unexpected_misalign");
                else m = mis_q.pop_front();
            end
            pv_req = dbus.dbus_req; pv_gnt = dbus.dbus_gnt; p_we = dbus.dbus_we;
            p_addr = dbus.dbus_addr; p_wdata = dbus.dbus_wdata; p_be = dbus.dbus_be;
            pv_v = mem_res_v; pv_ok = mem_ok; p_res = mem_res; p_rd = mem_rd;
        end
    end

    initial begin
        int k;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #4 check_reset_outputs();

        // fixed-latency bus: gnt with req, rvalid the next cycle, mem_ok always high
        fix_gnt = 0; fix_rv = 0; ok_mode = 1; noise_en = 0;
        preload(32'h1000, 32'h80FF_1234);
        issue(1'b0, LSU_B, 1'b0, 32'h1003, 32'h0, 5'd5);
        measure("load_lat_res_v", 1'b1, 3);
        measure("load_lat_ready", 1'b0, 1);
        issue(1'b0, LSU_B, 1'b1, 32'h1003, 32'h0, 5'd6);
        preload(32'h2000, 32'h1234_5678);
        issue(1'b0, LSU_H, 1'b0, 32'h2002, 32'h0, 5'd7);
        issue(1'b1, LSU_B, 1'b0, 32'h3001, 32'h0000_00AB, 5'd0);
        measure("store_lat_ready", 1'b0, 2);

        // grant stalled for three cycles
        fix_gnt = 3;
        issue(1'b1, LSU_W, 1'b0, 32'h3004, 32'hDEAD_BEEF, 5'd0);
        k = 0;
        do begin @(negedge clk); #4; if (dbus.dbus_req) k++; end while (dbus.dbus_req && k < 20);
        check("stall_req_cycles", k, 4);
        fix_gnt = 0;

        // result held while write_back withholds mem_ok
        ok_mode = 2;
        issue(1'b0, LSU_W, 1'b0, 32'h3004, 32'h0, 5'd9);
        k = 0;
        do begin @(negedge clk); #4; k++; end while (!mem_res_v && k < 20);
        if (!mem_res_v) fail("wait_res_v");
        repeat (5) begin @(negedge clk); #4; check("ok_low_ready", lsu_ready, 0); end
        ok_mode = 1;

        // misaligned and illegal ops: no bus traffic, next op accepted at once
        issue(1'b0, LSU_W, 1'b0, 32'h1002, 32'h0, 5'd3);
        issue(1'b1, 2'b11, 1'b0, 32'h1000, 32'h55, 5'd4);
        check("mis_next_accept", last_wait, 0);
        issue(1'b0, LSU_H, 1'b1, 32'h2000, 32'h0, 5'd8);
        check("mis_then_load_accept", last_wait, 0);
        measure("post_mis_res_v", 1'b1, 3);

        // reset while waiting for rvalid, then a stray rvalid in IDLE
        mute_rv = 1;
        issue(1'b0, LSU_W, 1'b0, 32'h2000, 32'h0, 5'd11);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        res_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0; mute_rv = 0; stray_req = 1;
        #4 check_reset_outputs();
        repeat (2) @(negedge clk);
        stray_req = 0;
        repeat (3) begin
            @(negedge clk); #4;
            check("stray_res_v", mem_res_v, 0);
            check("stray_idle", lsu_ready, 1);
        end
        issue(1'b0, LSU_B, 1'b0, 32'h2001, 32'h0, 5'd12);

        // randomized traffic
        fix_gnt = -1; fix_rv = -1; ok_mode = 0; noise_en = 1;
        for (int i = 0; i < 300; i++) begin
            logic [1:0] sz;
            sz = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                  32'h4000 + 32'($urandom_range(0, 31)), $urandom, 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 5) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        k = 0;
        while ((bus_q.size() + res_q.size() + mis_q.size()) != 0 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("drain_bus_q", bus_q.size(), 0);
        check("drain_res_q", res_q.size(), 0);
        check("drain_mis_q", mis_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
